// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester, transmitter and status bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);
  logic                          tick_i;
  logic [NumReq-1:0]             req_valid_i;
  logic [NumReq*DataWidth-1:0]   req_data_i;
  logic [NumReq-1:0]             req_last_i;
  logic [NumReq-1:0]             req_ready_o;
  logic                          tx_dv_o;
  logic [DataWidth-1:0]          tx_data_o;
  logic                          tx_busy_i;
  logic [NumReq-1:0]             grant_o;
  logic                          active_o;
  logic                          len_err_o;

  modport master (
    output tick_i, req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, tx_dv_o, tx_data_o, grant_o, active_o, len_err_o
  );

  modport slave (
    input  tick_i, req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, tx_dv_o, tx_data_o, grant_o, active_o, len_err_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmitter
module uart_tx_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int GapTicks  = 2,
  parameter int MaxPktLen = 16
) (
  input logic            clk_i,
  input logic            rst_ni,
  uart_tx_arbiter_if.slave bus
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxPktLen + 1);
  localparam int GapW = (GapTicks > 0) ? $clog2(GapTicks + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, GAP} state_t;

  state_t                 state_q;
  logic [NumReq-1:0]      grant_q;
  logic [IdxW-1:0]        owner_q;
  logic [IdxW-1:0]        ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [GapW-1:0]        gap_q;
  logic                   last_q;
  logic                   forced_q;
  logic                   tx_dv_q;
  logic [DataWidth-1:0]   tx_data_q;
  logic                   len_err_q;

  logic                   hit;
  logic [IdxW-1:0]        hit_idx;
  logic                   own_valid;
  logic                   own_last;
  logic [DataWidth-1:0]   own_data;
  logic [CntW-1:0]        cnt_inc;
  logic                   at_max;
  logic [GapW-1:0]        gap_inc;

  // Rotating search starting just after the last owner; sum stays below 2*NumReq.
  always_comb begin
    logic [IdxW:0] sum;
    hit     = 1'b0;
    hit_idx = '0;
    sum     = '0;
    for (int k = 1; k <= NumReq; k++) begin
      sum = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NumReq)) sum = sum - (IdxW+1)'(NumReq);
      if (!hit && bus.req_valid_i[sum[IdxW-1:0]]) begin
        hit     = 1'b1;
        hit_idx = sum[IdxW-1:0];
      end
    end
  end

  // Only the owner's lane is selected, so non-owner data never reaches tx_data.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_valid = bus.req_valid_i[i];
        own_last  = bus.req_last_i[i];
        own_data  = bus.req_data_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign at_max  = (cnt_inc == CntW'(MaxPktLen));
  assign gap_inc = gap_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= IdxW'(NumReq - 1);
      cnt_q     <= '0;
      gap_q     <= '0;
      last_q    <= 1'b0;
      forced_q  <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_data_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            owner_q <= hit_idx;
            ptr_q   <= hit_idx;
            grant_q <= NumReq'(1) << hit_idx;
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (own_valid && !bus.tx_busy_i) begin
            tx_data_q <= own_data;
            tx_dv_q   <= 1'b1;
            cnt_q     <= cnt_inc;
            last_q    <= own_last || at_max;
            forced_q  <= !own_last && at_max;
            state_q   <= SEND;
          end
        end
        SEND: state_q <= DRAIN;
        DRAIN: begin
          if (!bus.tx_busy_i) begin
            if (!last_q) begin
              state_q <= LOAD;
            end else begin
              grant_q   <= '0;
              len_err_q <= forced_q;
              state_q   <= (GapTicks == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (bus.tick_i) begin
            if (gap_inc == GapW'(GapTicks)) begin
              gap_q   <= '0;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state_q == LOAD && !bus.tx_busy_i) ? grant_q : '0;
  assign bus.tx_dv_o     = tx_dv_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.grant_o     = grant_q;
  assign bus.active_o    = (state_q == LOAD) || (state_q == SEND) || (state_q == DRAIN);
  assign bus.len_err_o   = len_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int GAP   = 2;
  localparam int MAXL  = 16;
  localparam int FRAME = 6;

  logic clk;
  logic rst_n;

  uart_tx_arbiter_if #(.NumReq(NR), .DataWidth(DW)) bus ();

  uart_tx_arbiter #(.NumReq(NR), .DataWidth(DW), .GapTicks(GAP), .MaxPktLen(MAXL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]  rq [NR][$];
  logic [9:0]  exp_q [$];
  int          hold [NR];
  int          sent_cnt [NR];
  bit          ext_busy;
  bit          model_busy;
  int          frame_cnt;
  int          tick_div;
  logic [NR-1:0] xfer_mask;
  bit          prev_dv;
  bit          prev_busy;
  logic [NR-1:0] prev_grant;
  bit          rel_seen;
  int          ticks_since_rel;
  int          grant_rise_cnt;
  int          len_err_cnt;
  logic [7:0]  last_sent;
  logic [7:0]  len_err_byte;
  int          checks;
  int          failures;

  // Transmitter model, requester drivers and output monitor, all away from posedge.
  initial begin
    forever begin
      logic [NR-1:0]    v;
      logic [NR-1:0]    l;
      logic [NR*DW-1:0] d;
      @(negedge clk);
      if (!rst_n) begin
        model_busy = 1'b0;
        frame_cnt  = 0;
        xfer_mask  = '0;
        rel_seen   = 1'b0;
      end else begin
        for (int i = 0; i < NR; i++)
          if (xfer_mask[i] && rq[i].size() > 0) begin
            void'(rq[i].pop_front());
            sent_cnt[i]++;
          end
        if (bus.tx_dv_o) begin
          model_busy = 1'b1;
          frame_cnt  = FRAME;
        end else if (frame_cnt > 0) begin
          frame_cnt--;
          if (frame_cnt == 0) model_busy = 1'b0;
        end
      end
      tick_div       = (tick_div + 1) % 4;
      bus.tick_i     = (tick_div == 0);
      bus.tx_busy_i  = model_busy | ext_busy;
      for (int i = 0; i < NR; i++) begin
        if (hold[i] > 0) hold[i]--;
        v[i] = (rq[i].size() > 0) && (hold[i] == 0);
        l[i] = v[i] ? rq[i][0][8] : 1'b0;
        d[i*DW +: DW] = v[i] ? rq[i][0][7:0] : 8'hxx;
      end
      bus.req_valid_i = v;
      bus.req_last_i  = l;
      bus.req_data_i  = d;
      #1;
      xfer_mask = bus.req_valid_i & bus.req_ready_o;
      if (rst_n) begin
        checks++;
        if (((bus.req_ready_o & ~bus.grant_o) != '0) || ($countones(bus.req_ready_o) > 1)) begin
          failures++;
          $display("FAIL ready_owner ready=%b grant=%b", bus.req_ready_o, bus.grant_o);
        end
        if (bus.tx_dv_o) begin
          checks++;
          if (prev_dv) begin
            failures++;
            $display("FAIL dv_width tx_dv high two cycles, data=%h", bus.tx_data_o);
          end
          if (prev_busy) begin
            failures++;
            $display("FAIL dv_while_busy tx_dv after busy LOAD cycle, data=%h", bus.tx_data_o);
          end
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte got=%h grant=%b required=none", bus.tx_data_o, bus.grant_o);
          end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if (bus.tx_data_o !== e[7:0] || bus.grant_o !== (NR'(1) << e[9:8])) begin
              failures++;
              $display("FAIL byte data=%h grant=%b required data=%h owner=%0d",
                       bus.tx_data_o, bus.grant_o, e[7:0], e[9:8]);
            end
          end
          last_sent = bus.tx_data_o;
        end
        if (bus.len_err_o) begin
          len_err_cnt++;
          len_err_byte = last_sent;
        end
        if (bus.grant_o == '0 && prev_grant != '0) begin
          rel_seen        = 1'b1;
          ticks_since_rel = 0;
        end
        if (bus.grant_o != '0 && prev_grant == '0) begin
          grant_rise_cnt++;
          if (rel_seen) begin
            checks++;
            if (ticks_since_rel < GAP) begin
              failures++;
              $display("FAIL gap ticks=%0d required>=%0d", ticks_since_rel, GAP);
            end
          end
        end
        if (bus.grant_o == '0 && bus.tick_i) ticks_since_rel++;
      end
      prev_dv    = bus.tx_dv_o;
      prev_busy  = bus.tx_busy_i;
      prev_grant = bus.grant_o;
    end
  end

  task automatic push_pkt(input int id, input int n, input int base);
    for (int j = 0; j < n; j++) begin
      rq[id].push_back({(j == n - 1), 8'(base + j)});
      exp_q.push_back({2'(id), 8'(base + j)});
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk); #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0 &&
          exp_q.size() == 0 && bus.grant_o == '0 && !bus.active_o && !model_busy) break;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout pending_exp=%0d grant=%b", name, exp_q.size(), bus.grant_o);
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (bus.grant_o !== '0 || bus.req_ready_o !== '0 || bus.tx_dv_o !== 1'b0 ||
        bus.tx_data_o !== '0 || bus.active_o !== 1'b0 || bus.len_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset grant=%b ready=%b dv=%b data=%h active=%b len_err=%b required all zero",
               bus.grant_o, bus.req_ready_o, bus.tx_dv_o, bus.tx_data_o, bus.active_o, bus.len_err_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin;
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20);
    push_pkt(2, 2, 8'h30);
    wait_idle("round_robin", 400);
    // pointer is now 2, so requester 3 outranks requester 0
    rq[0].push_back({1'b1, 8'h18});
    rq[3].push_back({1'b1, 8'h38});
    exp_q.push_back({2'd3, 8'h38});
    exp_q.push_back({2'd0, 8'h18});
    wait_idle("rr_pointer", 300);
  endtask

  task automatic test_single;
    int s0;
    s0 = sent_cnt[0];
    push_pkt(0, 1, 8'hA5);
    rq[0][0][8] = 1'b0;
    push_pkt(0, 1, 8'h3C);
    wait_idle("single", 300);
    push_pkt(0, 1, 8'h11);
    wait_idle("single_next", 300);
    checks++;
    if (sent_cnt[0] - s0 != 3) begin
      failures++;
      $display("FAIL single_count sent=%0d required=3", sent_cnt[0] - s0);
    end
  endtask

  task automatic test_stall;
    int s1;
    int n;
    s1 = sent_cnt[1];
    push_pkt(1, 3, 8'h40);
    push_pkt(3, 1, 8'h50);
    n = 0;
    while (sent_cnt[1] == s1 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    hold[1] = 20;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      #2;
      checks++;
      if (bus.grant_o !== 4'b0010 || bus.tx_dv_o !== 1'b0) begin
        failures++;
        $display("FAIL stall cycle=%0d grant=%b dv=%b required grant=0010 dv=0", c, bus.grant_o, bus.tx_dv_o);
      end
      @(negedge clk);
    end
    wait_idle("stall", 400);
  endtask

  task automatic test_max_len;
    int l0;
    int g0;
    l0 = len_err_cnt;
    g0 = grant_rise_cnt;
    push_pkt(2, 17, 8'h00);
    wait_idle("max_len", 2000);
    checks++;
    if (len_err_cnt - l0 != 1 || len_err_byte !== 8'h0F) begin
      failures++;
      $display("FAIL len_err pulses=%0d after_byte=%h required pulses=1 after_byte=0f",
               len_err_cnt - l0, len_err_byte);
    end
    checks++;
    if (grant_rise_cnt - g0 != 2) begin
      failures++;
      $display("FAIL max_len_grants grants=%0d required=2", grant_rise_cnt - g0);
    end
  endtask

  task automatic test_busy_hold;
    int s3;
    s3 = sent_cnt[3];
    ext_busy = 1'b1;
    push_pkt(3, 1, 8'h77);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      #2;
      checks++;
      if (bus.req_ready_o !== '0 || bus.tx_dv_o !== 1'b0 || bus.grant_o !== 4'b1000) begin
        failures++;
        $display("FAIL busy_hold ready=%b dv=%b grant=%b required ready=0 dv=0 grant=1000",
                 bus.req_ready_o, bus.tx_dv_o, bus.grant_o);
      end
      @(negedge clk);
    end
    ext_busy = 1'b0;
    wait_idle("busy_hold", 300);
    checks++;
    if (sent_cnt[3] - s3 != 1) begin
      failures++;
      $display("FAIL busy_hold_sent sent=%0d required=1", sent_cnt[3] - s3);
    end
  endtask

  task automatic test_async_reset;
    int n;
    push_pkt(0, 1, 8'h55);
    n = 0;
    while (n < 100) begin
      @(negedge clk); #2;
      if (bus.tx_dv_o) break;
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL async_reset_dv_timeout dv=%b required=1", bus.tx_dv_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tx_dv_o !== 1'b0 || bus.grant_o !== '0 || bus.req_ready_o !== '0 || bus.active_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset dv=%b grant=%b ready=%b active=%b required all zero",
               bus.tx_dv_o, bus.grant_o, bus.req_ready_o, bus.active_o);
    end
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    push_pkt(0, 1, 8'h67);
    rq[1].push_back({1'b1, 8'h66});
    exp_q.push_back({2'd1, 8'h66});
    wait_idle("after_reset", 300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    ext_busy = 1'b0; model_busy = 1'b0; frame_cnt = 0; tick_div = 0;
    xfer_mask = '0; prev_dv = 1'b0; prev_busy = 1'b0; prev_grant = '0;
    rel_seen = 1'b0; ticks_since_rel = 0; grant_rise_cnt = 0; len_err_cnt = 0;
    last_sent = '0; len_err_byte = '0;
    for (int i = 0; i < NR; i++) begin hold[i] = 0; sent_cnt[i] = 0; end
    bus.tick_i = 1'b0; bus.tx_busy_i = 1'b0;
    bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_data_i = '0;
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_max_len();
    test_busy_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
